// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: FSM states, run modes
// and stop-cause codes.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_BUDGET = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUDGET = 2'd1;
  localparam logic [1:0] CAUSE_HALT   = 2'd2;
  localparam logic [1:0] CAUSE_BP     = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller gating the CPU clock-enable (free-run/budget/step).
// Define CPU_RUN_CTRL_BREAKPOINT_EN to enable the PC breakpoint stop.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_CYCLES = 30,
  parameter int PC_W           = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Budget,
  input  logic             Step,
  input  logic             Halt,
  input  logic [PC_W-1:0]  Pc,
  input  logic [PC_W-1:0]  BpAddr,
  input  logic             BpValid,
  output logic             CpuEn,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       StopCause
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_DEF = CNT_W'(DEFAULT_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [1:0]       cause_q, cause_d;
  logic             run_q, done_q;
  logic             clr;
  logic             bp_hit;
  logic             at_last;
  logic             active;

  assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = active && BpValid && (Pc == BpAddr);
`else
  logic unused_bp;
  assign unused_bp = ^{Pc, BpAddr, BpValid};
  assign bp_hit    = 1'b0;
`endif

  assign CpuEn = active && !bp_hit;

  // Budget mode stops at the limit; other modes stop on saturation.
  assign at_last = (mode_q == MODE_BUDGET)
                 ? (CycleCount == limit_q - CNT_W'(1))
                 : (CycleCount == CNT_MAX - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    cause_d = cause_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          mode_d  = (Mode == MODE_RSVD) ? MODE_FREE : Mode;
          limit_d = (Budget == '0) ? CNT_DEF : Budget;
          cause_d = CAUSE_NONE;
          clr     = 1'b1;
          state_d = (Mode == MODE_STEP) ? ST_PAUSE : ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (Halt) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (bp_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_BP;
        end else if (CpuEn && at_last) begin
          state_d = ST_DONE;
          cause_d = CAUSE_BUDGET;
        end else if (state_q == ST_STEP) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (Halt) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (Step) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FREE;
      limit_q <= '0;
      cause_q <= CAUSE_NONE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      cause_q <= cause_d;
      run_q   <= (state_d == ST_RUN) ||
                 (state_d == ST_PAUSE) ||
                 (state_d == ST_STEP);
      done_q  <= (state_d == ST_DONE);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (clr),
    .en_i  (CpuEn),
    .cnt_o (CycleCount)
  );

  assign Running   = run_q;
  assign Done      = done_q;
  assign StopCause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a 16-bit instance for budget/step
// runs and a 4-bit instance for saturation and breakpoint runs.
module tb_cpu_run_ctrl;

  logic        Clock;
  logic        Reset;
  logic        Start, Start4;
  logic [1:0]  Mode;
  logic [15:0] Budget;
  logic        Step, Halt;
  logic        bpv4;
  logic [15:0] bpa4;
  logic [15:0] pc4;

  logic        en16, run16, done16;
  logic [15:0] cc16;
  logic [1:0]  sc16;
  logic        en4, run4, done4;
  logic [3:0]  cc4;
  logic [1:0]  sc4;

  int n_cmp = 0;
  int n_err = 0;
  int en_tot16 = 0, gap16 = 0;
  int en_tot4 = 0, gap4 = 0;
  logic [31:0] sb[$];

  assign pc4 = {12'b0, cc4};

  cpu_run_ctrl u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Mode       (Mode),
    .Budget     (Budget),
    .Step       (Step),
    .Halt       (Halt),
    .Pc         (16'h0000),
    .BpAddr     (16'h0000),
    .BpValid    (1'b0),
    .CpuEn      (en16),
    .Running    (run16),
    .Done       (done16),
    .CycleCount (cc16),
    .StopCause  (sc16)
  );

  cpu_run_ctrl #(
    .CNT_W (4)
  ) u_dut4 (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start4),
    .Mode       (Mode),
    .Budget     (4'h0),
    .Step       (Step),
    .Halt       (Halt),
    .Pc         (pc4),
    .BpAddr     (bpa4),
    .BpValid    (bpv4),
    .CpuEn      (en4),
    .Running    (run4),
    .Done       (done4),
    .CycleCount (cc4),
    .StopCause  (sc4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (en16) en_tot16++;
    if (run16 && !en16) gap16++;
    if (en4) en_tot4++;
    if (run4 && !en4) gap4++;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic pop(string tag, logic [31:0] obs);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0d want <scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic go16();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic go4();
    Start4 = 1'b1;
    tick();
    Start4 = 1'b0;
  endtask

  task automatic wait16(int max, string tag);
    int n = 0;
    while (!done16 && n < max) begin
      tick();
      n++;
    end
    if (!done16) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait4(int max, string tag);
    int n = 0;
    while (!done4 && n < max) begin
      tick();
      n++;
    end
    if (!done4) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, g;
    Reset = 1'b1; Start = 1'b0; Start4 = 1'b0;
    Mode = 2'b00; Budget = '0; Step = 1'b0; Halt = 1'b0;
    bpv4 = 1'b0; bpa4 = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    repeat (6) push(0);
    pop("rst_en", en16);
    pop("rst_run", run16);
    pop("rst_done", done16);
    pop("rst_cc", cc16);
    pop("rst_sc", sc16);
    pop("rst_cc4", cc4);

    // reset in the middle of a 100-cycle budget run
    Mode = 2'b01; Budget = 16'd100;
    go16();
    repeat (49) tick();
    push(49); push(1);
    pop("mid_cc", cc16);
    pop("mid_run", run16);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (5) push(0);
    pop("mrst_en", en16);
    pop("mrst_run", run16);
    pop("mrst_done", done16);
    pop("mrst_cc", cc16);
    pop("mrst_sc", sc16);
    b = en_tot16;
    go16();
    push(100); push(100); push(1);
    wait16(200, "fresh");
    pop("fresh_en", en_tot16 - b);
    pop("fresh_cc", cc16);
    pop("fresh_sc", sc16);

    // default budget when Budget==0
    Mode = 2'b01; Budget = 16'd0;
    b = en_tot16; g = gap16;
    go16();
    push(30); push(0); push(30); push(1); push(1); push(0);
    wait16(100, "dflt");
    pop("dflt_en", en_tot16 - b);
    pop("dflt_gap", gap16 - g);
    pop("dflt_cc", cc16);
    pop("dflt_sc", sc16);
    pop("dflt_done", done16);
    pop("dflt_run", run16);
    repeat (3) tick();
    push(30); push(30);
    pop("dflt_hold_cc", cc16);
    pop("dflt_hold_en", en_tot16 - b);

    // halt on the final budget enable
    Mode = 2'b01; Budget = 16'd5;
    b = en_tot16;
    go16();
    repeat (4) tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    push(5); push(5); push(2); push(1);
    wait16(5, "race");
    pop("race_en", en_tot16 - b);
    pop("race_cc", cc16);
    pop("race_sc", sc16);
    pop("race_done", done16);

    // single-step with an extra Step held during STEP
    Mode = 2'b10; Budget = 16'd0;
    b = en_tot16;
    go16();
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      Step = 1'b1;
      tick();
      Step = (i == 1);
      tick();
      Step = 1'b0;
      repeat (2) tick();
    end
    push(3); push(3); push(1); push(0);
    pop("step_en", en_tot16 - b);
    pop("step_cc", cc16);
    pop("step_run", run16);
    pop("step_done", done16);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    push(1); push(2); push(3); push(0);
    pop("step_halt_done", done16);
    pop("step_halt_sc", sc16);
    pop("step_halt_cc", cc16);
    pop("step_halt_run", run16);

    // 4-bit free-run to saturation, Start mid-run ignored
    Mode = 2'b00;
    b = en_tot4;
    go4();
    repeat (5) tick();
    go4();
    push(15); push(15); push(1); push(1);
    wait4(40, "sat");
    pop("sat_en", en_tot4 - b);
    pop("sat_cc", cc4);
    pop("sat_sc", sc4);
    pop("sat_done", done4);

    // breakpoint at Pc==7 with Pc following CycleCount
    Mode = 2'b00; bpa4 = 16'h0007; bpv4 = 1'b1;
    b = en_tot4; g = gap4;
    go4();
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    push(7); push(1); push(7); push(3);
`else
    push(15); push(0); push(15); push(1);
`endif
    wait4(40, "bp");
    pop("bp_en", en_tot4 - b);
    pop("bp_gap", gap4 - g);
    pop("bp_cc", cc4);
    pop("bp_sc", sc4);
    bpv4 = 1'b0;

    if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
